// File: rtl/adder_issue_queue.sv
// Operand issue queue feeding the pipelined adder.
// Operand pairs are buffered in a small FIFO and issued one per cycle into
// registered adder inputs. A valid bit travels alongside each issued pair
// through the adder's fixed latency, so that the adder output can be tagged
// with a result-valid strobe.
module adder_issue_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     stall,
  input  logic                     flush,
  output logic [WIDTH-1:0]         add_input1,
  output logic [WIDTH-1:0]         add_input2,
  input  logic [WIDTH-1:0]         add_out,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0]   a_mem [DEPTH];
  logic [WIDTH-1:0]   b_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               issue;
  // vld_p0 marks the pair currently held in add_input1/add_input2;
  // valid_sr then follows that pair through the adder's ADD_LAT stages.
  logic               vld_p0;
  logic [ADD_LAT-1:0] valid_sr;
  logic [ADD_LAT-1:0] valid_sr_nxt;

  // No bypass and no same-cycle pop credit: readiness depends only on occupancy.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign issue    = (count != '0) && !stall && !flush;

  assign res_valid = valid_sr[ADD_LAT-1];
  assign res_data  = add_out;

  // Next value of the latency tracker: shift every cycle, the adder never stalls.
  always_comb begin
    valid_sr_nxt    = valid_sr << 1;
    valid_sr_nxt[0] = vld_p0;
  end

  // ---- FIFO storage (data only, no reset needed) ----
  // Write the incoming pair at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr] <= in_a;
      b_mem[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- Stage p0: registered adder inputs ----
  // Load the head pair on issue; otherwise hold (flush also holds them).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_input1 <= '0;
      add_input2 <= '0;
    end else if (issue) begin
      add_input1 <= a_mem[rd_ptr];
      add_input2 <= b_mem[rd_ptr];
    end
  end

  // ---- Stages p1..pADD_LAT: in-flight valid tracking ----
  // Flush clears every in-flight tag so stale adder outputs are never flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      valid_sr <= '0;
    end else if (flush) begin
      vld_p0   <= 1'b0;
      valid_sr <= '0;
    end else begin
      vld_p0   <= issue;
      valid_sr <= valid_sr_nxt;
    end
  end

endmodule

// File: tb/tb_adder_issue_queue.sv
// Directed self-checking bench for adder_issue_queue with a one-cycle
// pipelined adder model wired to add_input1/add_input2/add_out.
module tb_adder_issue_queue;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] add_input1;
  logic [WIDTH-1:0] add_input2;
  logic [WIDTH-1:0] add_out;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  adder_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .stall(stall), .flush(flush),
    .add_input1(add_input1), .add_input2(add_input2), .add_out(add_out),
    .res_valid(res_valid), .res_data(res_data), .count(count)
  );

  // Adder model: one register stage, reset on the same net.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) add_out <= '0;
    else      add_out <= add_input1 + add_input2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [31:0] t3_a [4];
  logic [31:0] t3_b [4];
  logic [31:0] t3_s [4];
  logic [31:0] t6_s [9];

  initial begin
    int k;
    int pushed;
    int got;
    logic acc;

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; stall = 1'b0; flush = 1'b0;

    // 1. reset held two cycles
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_in1", add_input1, 0);
    chk("rst_in2", add_input2, 0);

    // 2. single pair latency
    rst = 1'b1; in_valid = 1'b1; in_a = 0; in_b = 10;
    tick();                                   // edge 0: push
    in_valid = 1'b0;
    chk("t2_count_e0", 32'(count), 1);
    chk("t2_rv_e0", 32'(res_valid), 0);
    tick();                                   // edge 1: issue
    chk("t2_in1_e1", add_input1, 0);
    chk("t2_in2_e1", add_input2, 10);
    chk("t2_rv_e1", 32'(res_valid), 0);
    tick();                                   // edge 2: result
    chk("t2_rv_e2", 32'(res_valid), 1);
    chk("t2_data_e2", res_data, 10);
    tick();
    chk("t2_rv_e3", 32'(res_valid), 0);

    // 3. back-to-back pairs including a wrapping sum
    t3_a[0] = 1000;     t3_b[0] = 10;    t3_s[0] = 1010;
    t3_a[1] = 12345;    t3_b[1] = 54321; t3_s[1] = 66666;
    t3_a[2] = 7;        t3_b[2] = 8;     t3_s[2] = 15;
    t3_a[3] = 32'hFFFFFFFF; t3_b[3] = 1; t3_s[3] = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_a = t3_a[i]; in_b = t3_b[i];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 2 && i <= 5) begin
        chk("t3_rv", 32'(res_valid), 1);
        chk("t3_data", res_data, t3_s[i-2]);
      end else if (i == 6) begin
        chk("t3_rv_end", 32'(res_valid), 0);
      end
    end

    // 4. fill under stall, then drain
    stall = 1'b1;
    k = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = k; in_b = k;
      acc = in_ready;
      tick();
      if (acc) k++;
    end
    chk("t4_accepted", k, 5);
    chk("t4_count_full", 32'(count), 4);
    chk("t4_ready_full", 32'(in_ready), 0);
    chk("t4_rv_stalled", 32'(res_valid), 0);
    stall = 1'b0;                             // (5,5) still offered
    tick();
    chk("t4_count_a", 32'(count), 3);
    chk("t4_ready_a", 32'(in_ready), 1);
    tick();                                   // (5,5) accepted
    in_valid = 1'b0;
    chk("t4_count_b", 32'(count), 3);
    chk("t4_rv_0", 32'(res_valid), 1);
    chk("t4_data_0", res_data, 2);
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("t4_rv", 32'(res_valid), 1);
      chk("t4_data", res_data, 32'(2 * (j + 1)));
    end
    chk("t4_count_empty", 32'(count), 0);
    tick();
    chk("t4_rv_end", 32'(res_valid), 0);

    // 5. flush with 3 queued and 1 in flight
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 20 + i; in_b = 1;
      tick();
    end
    chk("t5_count_pre", 32'(count), 4);
    in_valid = 1'b0; stall = 1'b0;
    tick();                                   // issue (20,1)
    chk("t5_count_issue", 32'(count), 3);
    chk("t5_in1_issue", add_input1, 20);
    flush = 1'b1; in_valid = 1'b1; in_a = 9; in_b = 9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_count_flush", 32'(count), 0);
    chk("t5_rv_flush", 32'(res_valid), 0);
    chk("t5_in1_hold", add_input1, 20);
    for (int i = 0; i < ADD_LAT + 2; i++) begin
      tick();
      chk("t5_rv_quiet", 32'(res_valid), 0);
      chk("t5_count_quiet", 32'(count), 0);
    end
    in_valid = 1'b1; in_a = 3; in_b = 4;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_in1_new", add_input1, 3);
    chk("t5_rv_new_early", 32'(res_valid), 0);
    tick();
    chk("t5_rv_new", 32'(res_valid), 1);
    chk("t5_data_new", res_data, 7);

    // 6. nine pairs with intermittent stall, pointers wrap twice
    for (int i = 0; i < 9; i++) t6_s[i] = 32'(i * 1000 + 7) + 32'(i * 3 + 1);
    pushed = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
      stall = ((cyc % 5) == 1) || ((cyc % 5) == 2) || (cyc < 4);
      if (pushed < 9) begin
        in_valid = 1'b1;
        in_a = 32'(pushed * 1000 + 7);
        in_b = 32'(pushed * 3 + 1);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) pushed++;
      chk("t6_count_max", 32'(count <= 4), 1);
      if (res_valid) begin
        chk("t6_data", res_data, t6_s[got]);
        got++;
      end
    end
    chk("t6_results", got, 9);
    stall = 1'b0; in_valid = 1'b0;

    // 1b. asynchronous reset mid-cycle
    stall = 1'b1; in_valid = 1'b1; in_a = 1; in_b = 2;
    tick();
    in_valid = 1'b0;
    chk("ar_count_pre", 32'(count), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_ready", 32'(in_ready), 1);
    chk("ar_in1", add_input1, 0);
    chk("ar_in2", add_input2, 0);
    chk("ar_rv", 32'(res_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
